// File: rtl/round_robin_arbit_pkg.sv
// ---------------------------------------------------------------------------
// round_robin_arbit_pkg
//   Shared types and helpers for the three-requester round-robin arbiter.
//   - N_REQ     : number of requesters (agent 1..N_REQ maps to index 0..N_REQ-1)
//   - idx_t     : last-grant pointer type, $clog2(N_REQ) bits wide
//   - req_t     : request / grant vector type, bit i = agent i+1
//   - LAST_RST  : pointer value after reset (last agent, so agent 1 wins first)
//   - rr_inc    : pointer increment wrapping at N_REQ-1 (not a power of two)
//   - rr_next   : reference round-robin pick returning a one-hot grant
// ---------------------------------------------------------------------------
package round_robin_arbit_pkg;

  localparam int N_REQ = 3;
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N_REQ-1:0] req_t;

  localparam idx_t LAST_RST = idx_t'(N_REQ - 1);

  // Next pointer value; wraps by comparison because N_REQ need not be 2**k.
  function automatic idx_t rr_inc(input idx_t i);
    idx_t r;
    if (i == idx_t'(N_REQ - 1)) begin
      r = idx_t'(0);
    end else begin
      r = i + idx_t'(1);
    end
    return r;
  endfunction

  // Scan from last+1 with wrap; first pending request gets the one-hot grant.
  function automatic req_t rr_next(input req_t req, input idx_t last);
    req_t gnt;
    idx_t idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = last;
    for (int k = 0; k < N_REQ; k++) begin
      idx = rr_inc(idx);
      if (!found && req[idx]) begin
        gnt   = req_t'(1) << idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/round_robin_arbit_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
//   Combinational round-robin priority selector.
//   Ports:
//     req     in  [N_REQ-1:0]  pending requests, bit i = agent i+1
//     last    in  idx_t        index of the most recently granted agent
//     gnt     out [N_REQ-1:0]  one-hot grant (all zero when req == 0)
//     gnt_idx out idx_t        index of the granted agent (0 when none)
//     any     out 1            at least one request is pending
//   The request vector is duplicated to 2*N_REQ bits; the lower copy is
//   masked at and below 'last', so a plain lowest-set-bit search starts just
//   after 'last' and wraps naturally into the upper copy. The upper copy
//   keeps bit 'last' itself, so a sole requester is re-granted every cycle.
// ---------------------------------------------------------------------------
module rr_priority_pick
  import round_robin_arbit_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  idx_t             last,
  output logic [N_REQ-1:0] gnt,
  output idx_t             gnt_idx,
  output logic             any
);

  localparam int DW = 2 * N_REQ;

  logic [DW-1:0] dbl_s;
  logic [DW-1:0] masked_s;
  logic          found_s;
  idx_t          idx_s;

  // Build the double-width request vector and mask the lower copy up to 'last'.
  always_comb begin
    dbl_s    = {req, req};
    masked_s = '0;
    for (int i = 0; i < DW; i++) begin
      masked_s[i] = dbl_s[i] & (i > int'(last));
    end
  end

  // Lowest-set-bit search; positions in the upper copy fold back by N_REQ.
  always_comb begin
    found_s = 1'b0;
    idx_s   = idx_t'(0);
    for (int i = 0; i < DW; i++) begin
      if (!found_s && masked_s[i]) begin
        found_s = 1'b1;
        if (i >= N_REQ) begin
          idx_s = idx_t'(i - N_REQ);
        end else begin
          idx_s = idx_t'(i);
        end
      end else begin
        found_s = found_s;
      end
    end
  end

  // Drive the one-hot grant from the found index.
  always_comb begin
    any     = found_s;
    gnt_idx = idx_s;
    if (found_s) begin
      gnt = req_t'(1) << idx_s;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/round_robin_arbit.sv
// ---------------------------------------------------------------------------
// round_robin_arbit
//   Three-requester round-robin arbiter with registered one-hot grants.
//   Arbitration is repeated every cycle (no lock): a persistent requester
//   yields after one grant cycle when others are waiting.
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-high reset (clears grants, pointer
//                     returns to agent 3 so agent 1 has top priority)
//     go1..go3   in   level requests from agents 1..3
//     get1..get3 out  registered one-hot grants to agents 1..3
// ---------------------------------------------------------------------------
module round_robin_arbit
  import round_robin_arbit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic go1,
  input  logic go2,
  input  logic go3,
  output logic get1,
  output logic get2,
  output logic get3
);

  req_t req_s;
  req_t pick_gnt_s;
  idx_t pick_idx_s;
  logic pick_any_s;
  req_t gnt_r;
  idx_t last_r;

  assign req_s = {go3, go2, go1};

  rr_priority_pick u_pick (
    .req     (req_s),
    .last    (last_r),
    .gnt     (pick_gnt_s),
    .gnt_idx (pick_idx_s),
    .any     (pick_any_s)
  );

  // Grant and last-grant pointer registers; pointer holds when nobody requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_r  <= '0;
      last_r <= LAST_RST;
    end else begin
      gnt_r <= pick_gnt_s;
      if (pick_any_s) begin
        last_r <= pick_idx_s;
      end else begin
        last_r <= last_r;
      end
    end
  end

  assign get1 = gnt_r[0];
  assign get2 = gnt_r[1];
  assign get3 = gnt_r[2];

endmodule

// File: tb/tb_round_robin_arbit.sv
// ---------------------------------------------------------------------------
// tb_round_robin_arbit
//   Directed stimulus with hand-computed grants. The stimulus process pushes
//   the expected {get3,get2,get1} for each issued request pattern; a monitor
//   pops and compares one entry per rising edge, and also checks that grants
//   are at most one-hot and only go to agents requesting at that edge.
// ---------------------------------------------------------------------------
module tb_round_robin_arbit;

  logic clk;
  logic rst;
  logic go1, go2, go3;
  logic get1, get2, get3;

  int total;
  int bad;

  logic [2:0] exp_q[$];
  logic [2:0] get_v;

  assign get_v = {get3, get2, get1};

  round_robin_arbit dut (
    .clk  (clk),
    .rst  (rst),
    .go1  (go1),
    .go2  (go2),
    .go3  (go3),
    .get1 (get1),
    .get2 (get2),
    .get3 (get3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%b want=%b at t=%0t", name, act, req, $time);
    end
  endtask

  // Issue one request pattern at a falling edge and queue its expected grant.
  task automatic step(input logic [2:0] g, input logic [2:0] e);
    {go3, go2, go1} = g;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare queued expectations and invariants just after each edge.
  initial begin
    logic [2:0] go_samp;
    logic [2:0] e;
    forever begin
      @(posedge clk);
      go_samp = {go3, go2, go1};
      #1;
      chk("onehot0", 3'(get_v & (get_v - 3'd1)), 3'b000);
      chk("grant_without_req", get_v & ~go_samp, 3'b000);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant_seq", get_v, e);
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    {go3, go2, go1} = 3'b000;

    // 1: reset state and idle
    #2;
    chk("reset_state", get_v, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    step(3'b000, 3'b000);
    step(3'b000, 3'b000);

    // 2: agent 1 alone, then release
    step(3'b001, 3'b001);
    step(3'b001, 3'b001);
    step(3'b000, 3'b000);

    // 3: after agent 1, go1+go3 alternates 3,1,3,1
    step(3'b101, 3'b100);
    step(3'b101, 3'b001);
    step(3'b101, 3'b100);
    step(3'b101, 3'b001);
    step(3'b000, 3'b000);

    // 4: fresh reset, all request -> 1,2,3,1,2,3
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step(3'b111, 3'b001);
    step(3'b111, 3'b010);
    step(3'b111, 3'b100);
    step(3'b111, 3'b001);
    step(3'b111, 3'b010);
    step(3'b111, 3'b100);

    // 5: last=3, go1+go2 wraps to 1, then alternates 2,1,2
    step(3'b011, 3'b001);
    step(3'b011, 3'b010);
    step(3'b011, 3'b001);
    step(3'b011, 3'b010);

    // sole requester re-granted every cycle
    step(3'b010, 3'b010);
    step(3'b010, 3'b010);

    // 6: async reset while get2 is high, no clock edge in between
    #2;
    chk("get2_before_rst", get_v, 3'b010);
    rst = 1'b1;
    #1;
    chk("async_rst_clear", get_v, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    step(3'b111, 3'b001);
    step(3'b111, 3'b010);
    step(3'b000, 3'b000);

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
